// File: rtl/lockstep_checker.sv
// lockstep_checker
//   Compares each DUT retirement against a buffered expected entry on
//   CHANNELS lanes. Expected entries ({last, mask, data}) are queued in an
//   internal FIFO. The checker keeps saturating vector and error counts,
//   captures the first failing vector, and reports done/pass.
//
// Ports
//   clk, reset          rising-edge clock, async active-low reset
//   start               IDLE -> RUN request
//   exp_valid/ready     expected-entry handshake (ready = !full)
//   exp_data/mask/last  expected lanes (lane l at [l*WIDTH +: WIDTH]), check mask, final flag
//   obs_valid/data      DUT retirement strobe and observed lanes
//   state, done, pass   FSM state (IDLE=0 RUN=1 DONE=2 HALT=3) and verdict
//   mismatch            one-cycle pulse per failing vector
//   underflow           sticky: retirement seen with the FIFO empty
//   vector_count, error_count, first_err_*  statistics and first-failure capture
module lockstep_checker #(
    parameter int WIDTH         = 64,
    parameter int CHANNELS      = 2,
    parameter int DEPTH         = 64,
    parameter int CNT_W         = 32,
    parameter int STOP_ON_ERROR = 0,
    localparam int LW           = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      exp_valid,
    output logic                      exp_ready,
    input  logic [CHANNELS*WIDTH-1:0] exp_data,
    input  logic [CHANNELS-1:0]       exp_mask,
    input  logic                      exp_last,
    input  logic                      obs_valid,
    input  logic [CHANNELS*WIDTH-1:0] obs_data,
    output logic [1:0]                state,
    output logic                      done,
    output logic                      pass,
    output logic                      mismatch,
    output logic                      underflow,
    output logic [CNT_W-1:0]          vector_count,
    output logic [CNT_W-1:0]          error_count,
    output logic                      first_err_valid,
    output logic [CNT_W-1:0]          first_err_index,
    output logic [LW-1:0]             first_err_lane,
    output logic [WIDTH-1:0]          first_err_expected,
    output logic [WIDTH-1:0]          first_err_actual
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = 1 + CHANNELS + CHANNELS * WIDTH;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2, HALT = 2'd3} state_t;

    state_t st, st_nx;

    // Expected FIFO
    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count, count_nx;
    logic          full;
    logic          empty;

    logic [EW-1:0]               head;
    logic                        head_last;
    logic [CHANNELS-1:0]         head_mask;
    logic [CHANNELS*WIDTH-1:0]   head_data;

    logic                push_en, pop, under;
    logic [CHANNELS-1:0] lane_err;
    logic                any_err, vec_fail;
    logic [LW-1:0]       err_lane;
    logic [WIDTH-1:0]    sel_exp, sel_act;

    assign empty     = (count == '0);
    assign exp_ready = !full;

    // Handshakes still complete in DONE/HALT, but the entry is dropped.
    assign push_en = exp_valid && !full && (st == IDLE || st == RUN);
    assign pop     = (st == RUN) && obs_valid && !empty;
    assign under   = (st == RUN) && obs_valid && empty;

    assign head      = mem[rd_ptr];
    assign head_last = head[EW-1];
    assign head_mask = head[EW-2 -: CHANNELS];
    assign head_data = head[CHANNELS*WIDTH-1:0];

    for (genvar l = 0; l < CHANNELS; l++) begin : g_lane
        assign lane_err[l] = head_mask[l] &&
                             (obs_data[l*WIDTH +: WIDTH] != head_data[l*WIDTH +: WIDTH]);
    end

    assign any_err  = |lane_err;
    assign vec_fail = (pop && any_err) || under;

    // Lowest failing lane wins: scan downward so the last hit is the lowest.
    always_comb begin
        err_lane = '0;
        sel_exp  = '0;
        sel_act  = '0;
        for (int l = CHANNELS - 1; l >= 0; l--) begin
            if (lane_err[l]) begin
                err_lane = LW'(l);
                sel_exp  = head_data[l*WIDTH +: WIDTH];
                sel_act  = obs_data[l*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        case ({push_en, pop})
            2'b10:   count_nx = count + 1'b1;
            2'b01:   count_nx = count - 1'b1;
            default: count_nx = count;
        endcase
    end

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
        return (&x) ? x : x + 1'b1;
    endfunction

    // Next state; a 'last' entry takes priority over stop-on-error.
    always_comb begin
        st_nx = st;
        case (st)
            IDLE: if (start) st_nx = RUN;
            RUN: begin
                if (pop) begin
                    if (head_last)                          st_nx = DONE;
                    else if (any_err && STOP_ON_ERROR != 0) st_nx = HALT;
                end else if (under && STOP_ON_ERROR != 0) begin
                    st_nx = HALT;
                end
            end
            default: st_nx = st;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) st <= IDLE;
        else        st <= st_nx;
    end

    // Storage carries no reset; occupancy is tracked by count/pointers.
    always_ff @(posedge clk) begin
        if (push_en) mem[wr_ptr] <= {exp_last, exp_mask, exp_data};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
        end else begin
            if (push_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            count <= count_nx;
            full  <= (count_nx == FULL_CNT);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vector_count       <= '0;
            error_count        <= '0;
            mismatch           <= 1'b0;
            underflow          <= 1'b0;
            first_err_valid    <= 1'b0;
            first_err_index    <= '0;
            first_err_lane     <= '0;
            first_err_expected <= '0;
            first_err_actual   <= '0;
        end else begin
            mismatch <= vec_fail;
            if (pop || under) vector_count <= sat_inc(vector_count);
            if (vec_fail)     error_count  <= sat_inc(error_count);
            if (under)        underflow    <= 1'b1;
            if (vec_fail && !first_err_valid) begin
                first_err_valid    <= 1'b1;
                first_err_index    <= vector_count;
                first_err_lane     <= under ? '0 : err_lane;
                first_err_expected <= under ? '0 : sel_exp;
                first_err_actual   <= under ? obs_data[WIDTH-1:0] : sel_act;
            end
        end
    end

    assign state = st;
    assign done  = (st == DONE) || (st == HALT);
    assign pass  = done && (error_count == '0) && !underflow;

endmodule

// File: tb/tb_lockstep_checker.sv
// Bench for lockstep_checker: DUT a (DEPTH=4, run-to-completion) is checked by
// a scoreboard monitor; DUT b (DEPTH=8, STOP_ON_ERROR=1) covers the halt path.
module tb_lockstep_checker;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start_a = 1'b0, start_b = 1'b0;
    logic         exp_valid_a = 1'b0, exp_valid_b = 1'b0;
    logic         obs_valid_a = 1'b0, obs_valid_b = 1'b0;
    logic [127:0] exp_data = '0, obs_data = '0;
    logic [1:0]   exp_mask = '0;
    logic         exp_last = 1'b0;

    logic        exp_ready_a, done_a, pass_a, mismatch_a, underflow_a, fev_a;
    logic [1:0]  state_a;
    logic [31:0] vc_a, ec_a, fei_a;
    logic [0:0]  fel_a;
    logic [63:0] fee_a, fea_a;

    logic        exp_ready_b, done_b, pass_b, mismatch_b, underflow_b, fev_b;
    logic [1:0]  state_b;
    logic [31:0] vc_b, ec_b, fei_b;
    logic [0:0]  fel_b;
    logic [63:0] fee_b, fea_b;

    always #5 clk = ~clk;

    lockstep_checker #(.WIDTH(64), .CHANNELS(2), .DEPTH(4), .CNT_W(32), .STOP_ON_ERROR(0)) dut_a (
        .clk(clk), .reset(reset), .start(start_a),
        .exp_valid(exp_valid_a), .exp_ready(exp_ready_a), .exp_data(exp_data),
        .exp_mask(exp_mask), .exp_last(exp_last),
        .obs_valid(obs_valid_a), .obs_data(obs_data),
        .state(state_a), .done(done_a), .pass(pass_a), .mismatch(mismatch_a),
        .underflow(underflow_a), .vector_count(vc_a), .error_count(ec_a),
        .first_err_valid(fev_a), .first_err_index(fei_a), .first_err_lane(fel_a),
        .first_err_expected(fee_a), .first_err_actual(fea_a));

    lockstep_checker #(.WIDTH(64), .CHANNELS(2), .DEPTH(8), .CNT_W(32), .STOP_ON_ERROR(1)) dut_b (
        .clk(clk), .reset(reset), .start(start_b),
        .exp_valid(exp_valid_b), .exp_ready(exp_ready_b), .exp_data(exp_data),
        .exp_mask(exp_mask), .exp_last(exp_last),
        .obs_valid(obs_valid_b), .obs_data(obs_data),
        .state(state_b), .done(done_b), .pass(pass_b), .mismatch(mismatch_b),
        .underflow(underflow_b), .vector_count(vc_b), .error_count(ec_b),
        .first_err_valid(fev_b), .first_err_index(fei_b), .first_err_lane(fel_b),
        .first_err_expected(fee_b), .first_err_actual(fea_b));

    typedef struct {
        logic [31:0] vc;
        logic [31:0] ec;
        logic        mm;
    } exp_t;

    exp_t        sb[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] m_vc = 0, m_ec = 0;
    logic [31:0] prev_vc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, act, want);
        end
    endtask

    // Scoreboard monitor for DUT a: each counted vector must match the next
    // queued expectation, and mismatch must be low whenever no vector landed.
    always @(negedge clk) begin
        if (!reset) begin
            prev_vc = 0;
        end else if (vc_a != prev_vc) begin
            prev_vc = vc_a;
            if (sb.size() == 0) begin
                chk("sb_unexpected_vector", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_vector_count", vc_a, e.vc);
                chk("sb_error_count", ec_a, e.ec);
                chk("sb_mismatch", mismatch_a, e.mm);
            end
        end else begin
            chk("sb_mismatch_idle", mismatch_a, 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: timeout, want $finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        m_vc = 0;
        m_ec = 0;
        sb.delete();
        reset = 1'b1;
        tick();
    endtask

    task automatic push(input bit to_b, input logic [63:0] l0, input logic [63:0] l1,
                        input logic [1:0] m, input logic last);
        int t = 0;
        while (!(to_b ? exp_ready_b : exp_ready_a) && t < 50) begin
            tick();
            t++;
        end
        if (t >= 50) chk("push_ready_timeout", 0, 1);
        if (to_b) exp_valid_b = 1'b1; else exp_valid_a = 1'b1;
        exp_data = {l1, l0};
        exp_mask = m;
        exp_last = last;
        tick();
        exp_valid_a = 1'b0;
        exp_valid_b = 1'b0;
        exp_last    = 1'b0;
    endtask

    // Retirement into DUT a with its expected outcome queued for the monitor.
    task automatic obs_a(input logic [63:0] l0, input logic [63:0] l1, input logic err);
        exp_t e;
        obs_valid_a = 1'b1;
        obs_data = {l1, l0};
        m_vc++;
        if (err) m_ec++;
        e.vc = m_vc;
        e.ec = m_ec;
        e.mm = err;
        sb.push_back(e);
        tick();
        obs_valid_a = 1'b0;
    endtask

    function automatic logic [63:0] l0v(input int i);
        return 64'(i * 3 + 1);
    endfunction
    function automatic logic [63:0] l1v(input int i);
        return 64'(i * 5 + 2);
    endfunction

    initial begin
        // ---- reset state ----
        do_reset();
        chk("rst_state", state_a, 0);
        chk("rst_exp_ready", exp_ready_a, 1);
        chk("rst_done", done_a, 0);
        chk("rst_pass", pass_a, 0);
        chk("rst_vc", vc_a, 0);
        chk("rst_ec", ec_a, 0);
        chk("rst_underflow", underflow_a, 0);
        chk("rst_fev", fev_a, 0);
        chk("rst_mismatch", mismatch_a, 0);

        // ---- clean run with a masked lane ----
        push(0, 64'd1, 64'd2, 2'b11, 0);
        push(0, 64'd5, 64'hDEAD, 2'b01, 0);
        push(0, 64'd7, 64'd8, 2'b11, 1);
        obs_valid_a = 1'b1; obs_data = '1;
        tick();
        obs_valid_a = 1'b0;
        chk("idle_obs_ignored", vc_a, 0);
        start_a = 1'b1; tick(); start_a = 1'b0;
        chk("run_state", state_a, 1);
        obs_a(64'd1, 64'd2, 0);
        obs_a(64'd5, 64'hBEEF, 0);
        obs_a(64'd7, 64'd8, 0);
        chk("clean_state", state_a, 2);
        chk("clean_done", done_a, 1);
        chk("clean_pass", pass_a, 1);
        chk("clean_fev", fev_a, 0);
        obs_valid_a = 1'b1; obs_data = '0;
        tick();
        obs_valid_a = 1'b0;
        chk("done_obs_ignored", vc_a, 3);
        chk("done_holds", state_a, 2);
        tick();
        chk("clean_sb_drained", sb.size(), 0);

        // ---- first-error capture ----
        do_reset();
        for (int i = 0; i < 4; i++)
            push(0, l0v(i), (i == 2) ? 64'h10 : l1v(i), 2'b11, 0);
        chk("fifo_full_ready", exp_ready_a, 0);
        start_a = 1'b1; tick(); start_a = 1'b0;
        obs_a(l0v(0), l1v(0), 0);
        push(0, l0v(4), l1v(4), 2'b11, 1);
        obs_a(l0v(1), l1v(1), 0);
        obs_a(l0v(2), 64'h11, 1);
        obs_a(l0v(3), l1v(3), 0);
        obs_a(64'hFF, 64'hEE, 1);
        tick();
        chk("fe_ec", ec_a, 2);
        chk("fe_valid", fev_a, 1);
        chk("fe_index", fei_a, 2);
        chk("fe_lane", fel_a, 1);
        chk("fe_expected", fee_a, 64'h10);
        chk("fe_actual", fea_a, 64'h11);
        chk("fe_state", state_a, 2);
        chk("fe_pass", pass_a, 0);
        chk("fe_sb_drained", sb.size(), 0);

        // ---- full FIFO, held offer, simultaneous push/pop, pointer wrap ----
        do_reset();
        for (int i = 0; i < 4; i++) push(0, l0v(i), l1v(i), 2'b11, 0);
        chk("wrap_full", exp_ready_a, 0);
        exp_valid_a = 1'b1; exp_data = {l1v(4), l0v(4)}; exp_mask = 2'b11; exp_last = 1'b0;
        start_a = 1'b1; tick(); start_a = 1'b0;
        chk("wrap_held_ready", exp_ready_a, 0);
        chk("wrap_run", state_a, 1);
        for (int i = 0; i < 10; i++) begin
            int k;
            k = (i == 0) ? 4 : i + 3;
            exp_valid_a = (i <= 6);
            exp_data = {l1v(k), l0v(k)};
            exp_last = (k == 9);
            obs_a(l0v(i), l1v(i), 0);
        end
        exp_valid_a = 1'b0; exp_last = 1'b0;
        tick();
        chk("wrap_vc", vc_a, 10);
        chk("wrap_state", state_a, 2);
        chk("wrap_pass", pass_a, 1);
        chk("wrap_sb_drained", sb.size(), 0);

        // ---- underflow then asynchronous reset mid-run ----
        do_reset();
        start_a = 1'b1; tick(); start_a = 1'b0;
        obs_a(64'hABC, 64'h1, 1);
        chk("uf_flag", underflow_a, 1);
        chk("uf_state", state_a, 1);
        chk("uf_fel", fel_a, 0);
        chk("uf_fee", fee_a, 0);
        chk("uf_fea", fea_a, 64'hABC);
        tick();
        chk("uf_sb_drained", sb.size(), 0);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_state", state_a, 0);
        chk("async_rst_vc", vc_a, 0);
        chk("async_rst_ec", ec_a, 0);
        chk("async_rst_underflow", underflow_a, 0);
        chk("async_rst_fev", fev_a, 0);
        chk("async_rst_fea", fea_a, 0);
        chk("async_rst_ready", exp_ready_a, 1);
        do_reset();

        // ---- STOP_ON_ERROR=1 on DUT b ----
        for (int i = 0; i < 5; i++) push(1, l0v(i), l1v(i), 2'b11, i == 4);
        start_b = 1'b1; tick(); start_b = 1'b0;
        obs_valid_b = 1'b1; obs_data = {l1v(0), l0v(0)}; tick();
        obs_data = {l1v(1), 64'h0}; tick();
        chk("halt_state", state_b, 3);
        chk("halt_mismatch", mismatch_b, 1);
        obs_data = {l1v(2), l0v(2)}; tick();
        obs_valid_b = 1'b0;
        chk("halt_mismatch_low", mismatch_b, 0);
        chk("halt_vc", vc_b, 2);
        chk("halt_ec", ec_b, 1);
        chk("halt_fei", fei_b, 1);
        chk("halt_done", done_b, 1);
        chk("halt_pass", pass_b, 0);

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lockstep_checker.md
Name: lockstep_checker

Overview:
- Synthesizable, parametrised lockstep result checker for core bring-up benches and FPGA self-test.
- Buffers expected per-retirement values in an internal FIFO and compares each DUT retirement against the FIFO head across CHANNELS result lanes, e.g. Rd1/Rd2/writeback.
- Keeps vector and error counts, captures the first failure, and flags completion and pass/fail without simulator-only constructs.

Parameters:
- WIDTH, 64: bits per lane (32 for RV32I, 64 for RV64I).
- CHANNELS, 2: number of compared lanes, ≥1.
- DEPTH, 64: expected-FIFO entries, power of two, ≥2.
- CNT_W, 32: counter width.
- STOP_ON_ERROR, 0: 1 = halt on the first mismatching vector.

Ports:
- clk  in  1  clock, rising-edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  IDLE→RUN request.
- exp_valid  in  1  expected entry offered.
- exp_ready  out  1  FIFO can accept an entry (= !full).
- exp_data  in  CHANNELS*WIDTH  expected values; lane l at [l*WIDTH +: WIDTH].
- exp_mask  in  CHANNELS  1 = check lane, 0 = don't-care.
- exp_last  in  1  marks the final expected entry.
- obs_valid  in  1  DUT retired a result this cycle.
- obs_data  in  CHANNELS*WIDTH  observed values, same packing as exp_data.
- state  out  2  IDLE=0, RUN=1, DONE=2, HALT=3.
- done  out  1  state is DONE or HALT.
- pass  out  1  done && error_count==0 && !underflow.
- mismatch  out  1  one-cycle pulse per failing vector.
- underflow  out  1  sticky; obs_valid arrived with the FIFO empty in RUN.
- vector_count  out  CNT_W  vectors checked.
- error_count  out  CNT_W  failing vectors.
- first_err_valid  out  1  first-error capture holds data.
- first_err_index  out  CNT_W  vector_count value of the first failing vector.
- first_err_lane  out  max(1,$clog2(CHANNELS))  lowest failing lane.
- first_err_expected  out  WIDTH  expected value on that lane.
- first_err_actual  out  WIDTH  observed value on that lane.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, FIFO empty, exp_ready=1, and every other output 0.
- FIFO:
  - Push when exp_valid && exp_ready, in any state; entries pushed in DONE or HALT are discarded.
  - Entry = {last, mask, data}.
  - exp_ready is derived from the registered full flag.
  - Push and pop in the same cycle are allowed. Count is unchanged and pointers wrap modulo DEPTH.
  - No bypass: an entry pushed in cycle N is comparable from cycle N+1.
- IDLE: waits with start=1 → RUN next edge. obs_valid is ignored and nothing is counted.
- RUN, obs_valid=1 and FIFO non-empty:
  - Pop the head.
  - lane_err[l] = mask[l] && (obs lane l != exp lane l).
  - vector_count increments.
  - If any lane_err: error_count increments (once per vector, not per lane) and mismatch pulses on the next cycle.
  - On the first failing vector only, capture index = pre-increment vector_count, lowest failing lane, expected and actual; set first_err_valid.
  - Next state: head last=1 → DONE. Otherwise any lane_err with STOP_ON_ERROR=1 → HALT. Otherwise stay in RUN.
  - Last and error together: DONE has priority; the error is still counted.
- RUN, obs_valid=1 and FIFO empty:
  - Set underflow.
  - vector_count and error_count increment and mismatch pulses.
  - First-error capture (if still empty): lane 0, expected 0, actual = obs lane 0.
  - STOP_ON_ERROR=1 → HALT.
- RUN, obs_valid=0: no action.
- DONE / HALT: terminal until reset. start, obs_valid and pushes are ignored and all outputs hold.
- Counters saturate at all-ones and never wrap.
- Latency: counters, state and capture registers are updated at the comparing edge. mismatch is registered and asserts for exactly the following cycle.
- reset asserted mid-run aborts immediately and returns to reset values; FIFO contents are lost.

Test Plan:
- Clean run: WIDTH=64, CHANNELS=2; push 3 entries with the last on the 3rd, start, 3 matching obs → vector_count=3, error_count=0, state=DONE, pass=1.
- Masked lane: exp lane1=0xDEAD with mask=2'b01, obs lane1=0xBEEF, lane0 match → no mismatch, error_count=0.
- First-error capture: vector 2, lane1 exp 0x10 vs obs 0x11, then vector 4 also bad → error_count=2, first_err_index=2, lane=1, expected=0x10, actual=0x11; mismatch pulses twice, 1 cycle each.
- STOP_ON_ERROR=1: 5 entries, mismatch at vector 1 → state=HALT at the next edge, vector_count=2, later obs ignored, pass=0.
- Full/wrap: DEPTH=4; push 4 entries → exp_ready=0; a 5th offer is held; pop 1 with a simultaneous push → accepted; 10 vectors total through the wrap → vector_count=10, all match.
- Underflow and reset: obs_valid in RUN with the FIFO empty → underflow=1, error_count=1; then reset=0 mid-run → all outputs 0 and state=IDLE asynchronously.
